rr_mux_reg: RTL
===============

// Module: rr_mux_reg
// PURPOSE
//  Parametrised N-channel, W-bit registered multiplexer with round-robin arbitration.
//  Each input channel uses a valid/ready handshake. One winner per cycle is loaded
//  into a single-entry output register, and the output side also handshakes.
//  Used as the shared-bus merge point ahead of the decoder/display datapath.
// PARAMETERS
//  WIDTH     8   data bits per channel
//  CHANNELS  4   number of input channels (>=2)
//  SEL_W     $clog2(CHANNELS)  localparam, index width; never overridden
// PORTS
//  clk        in   1               single clock; all state updates on rising edge
//  rst        in   1               synchronous, active-high reset
//  in_data    in   CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS        per-channel request
//  in_ready   out  CHANNELS        per-channel accept, one-hot or zero
//  out_data   out  WIDTH           registered data
//  out_sel    out  SEL_W           index of the channel that supplied out_data
//  out_valid  out  1               output register holds a word
//  out_ready  in   1               downstream accept
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_sel=0, ptr=CHANNELS-1 (channel 0 wins first).
//  - load = ~out_valid | out_ready (register empty, or draining this cycle).
//  - Arbitration is combinational. Search in_valid starting at ptr+1 and wrap modulo
//    CHANNELS. The first set bit wins; grant is one-hot or zero.
//  - in_ready = grant & {CHANNELS{load}}. A transfer on channel i is in_valid[i] & in_ready[i].
//  - On a transfer: out_data<=in word i, out_sel<=i, out_valid<=1, ptr<=i.
//  - If load and no requester: out_valid<=0. out_data and out_sel hold their values.
//  - If ~load (out_valid & ~out_ready): all in_ready=0, and the register and ptr hold.
//  - Latency: input transfer at edge k gives out_valid at edge k+1.
//  - Throughput: 1 word/cycle while out_ready=1.
//  - Fairness: with all channels requesting, grants cycle 0,1,..,N-1,0. Each requester
//    waits at most N-1 grants.
//  - ptr wraps from CHANNELS-1 to 0. Non-power-of-2 CHANNELS never selects an
//    index >= CHANNELS.
//  - in_ready depends combinationally on in_valid. in_valid must not depend on in_ready.
//  - rst mid-stream overrides everything that cycle: the held word is dropped,
//    in_ready=0 during rst, and ptr returns to CHANNELS-1.
// CONFIGURATION
//  RR_MUX_REG_HOLD_EN
//   defined: adds ports in_last (in, CHANNELS) and out_last (out, 1).
//    - After a transfer with in_last[i]=0, the grant is locked to channel i.
//    - Other channels get in_ready=0 until channel i transfers with in_last[i]=1.
//    - ptr advances only on the last beat.
//    - out_last is registered with out_data; reset value is 0.
//    - The lock clears on rst.
//   undefined: no last ports; arbitration is re-run every word.
// STRUCTURE
//  - Shared package rr_mux_pkg holds:
//    - localparam function clog2_safe (returns 1 for CHANNELS<=2)
//    - typedef-equivalent width constants for the default configuration
//  - Sub-module rr_arbiter (params CHANNELS):
//    - inputs: req, ptr, en
//    - outputs: grant (one-hot), grant_idx
//    - rotate, priority-encode and unrotate
//  - The top level keeps the output register, ptr, lock state and handshake glue.
// TESTING
//  1 Reset: rst=1 for 2 cycles with random inputs -> out_valid=0, out_data=0,
//    out_sel=0, in_ready=0.
//  2 Single channel: in_valid=4'b0100, data2=8'hA5, out_ready=1 -> in_ready=4'b0100;
//    next cycle out_data=A5, out_sel=2, out_valid=1.
//  3 Fairness: in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_sel sequence
//    0,1,2,3,0,1,2,3.
//  4 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_sel stable,
//    in_ready=0. Release -> next word loads the same edge.
//  5 Wrap and reset: CHANNELS=3, grant sequence hits 2 then wraps to 0.
//    Assert rst while out_valid=1 -> out_valid=0 next edge, next grant is channel 0.
//  6 HOLD_EN: ch1 sends 3 beats (last on beat 3) while ch0 and ch3 request ->
//    out_sel=1,1,1 then 3, then 0, and out_last=0,0,1.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin registered multiplexer.
package rr_mux_pkg;

    // Index width that stays at least 1 bit even for a 2-channel (or smaller) mux.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DefaultWidth    = 8;
    localparam int unsigned DefaultChannels = 4;
    localparam int unsigned DefaultSelW     = clog2_safe(DefaultChannels);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo CHANNELS.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = DefaultChannels,
    localparam int unsigned SEL_W    = clog2_safe(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic        found;
    int unsigned idx;

    // Walk the rotated request vector; the modulo keeps non-power-of-2 sizes in range.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            idx = (32'(ptr) + k) % CHANNELS;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel registered mux with round-robin arbitration and valid/ready on both sides.
// Optional packet hold (in_last/out_last) is enabled with `define RR_MUX_REG_HOLD_EN.
module rr_mux_reg
    import rr_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = DefaultWidth,
    parameter  int unsigned CHANNELS = DefaultChannels,
    localparam int unsigned SEL_W    = clog2_safe(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef RR_MUX_REG_HOLD_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_sel_q;
    logic                out_valid_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    win_data;
    logic                load;
    logic                xfer;

    assign load = ~out_valid_q | out_ready;

`ifdef RR_MUX_REG_HOLD_EN
    logic             lock_q;
    logic [SEL_W-1:0] lock_idx_q;
    logic             out_last_q;

    // While a packet is open only its owner may compete.
    always_comb begin
        req = in_valid;
        if (lock_q) begin
            req = in_valid & (CHANNELS'(1) << lock_idx_q);
        end
    end
    assign out_last = out_last_q;
`else
    assign req = in_valid;
`endif

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .req       (req),
        .ptr       (ptr_q),
        .en        (load & ~rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready = grant;
    assign xfer     = |grant;
    assign win_data = in_data[grant_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= SEL_W'(CHANNELS - 1);
`ifdef RR_MUX_REG_HOLD_EN
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            out_last_q  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= win_data;
            out_sel_q   <= grant_idx;
`ifdef RR_MUX_REG_HOLD_EN
            out_last_q  <= in_last[grant_idx];
            // Pointer only moves once the packet closes, so the next packet starts fair.
            if (in_last[grant_idx]) begin
                lock_q <= 1'b0;
                ptr_q  <= grant_idx;
            end else begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant_idx;
            end
`else
            ptr_q       <= grant_idx;
`endif
        end else if (load) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
